tx_arbiter: RTL and testbench

TX_ARBITER -- requirements
Module: tx_arbiter

---
 rtl/tx_arbiter_pkg.sv | 21 ++
 rtl/tx_serializer.sv | 99 +++++++++
 rtl/tx_arbiter.sv | 88 ++++++++
 tb/tb_tx_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/tx_arbiter_pkg.sv
// Shared transmit definitions: command encodings, header start bit and
// per-command payload length.
package tx_arbiter_pkg;

   localparam int TX_CMD_BITS = 2;

   localparam logic [TX_CMD_BITS-1:0] TX_HEADER_READ_16  = 2'd1;
   localparam logic [TX_CMD_BITS-1:0] TX_HEADER_WRITE_16 = 2'd2;
   localparam logic [TX_CMD_BITS-1:0] TX_HEADER_WRITE_8  = 2'd3;

   localparam logic TX_START_BIT = 1'b1;

   // Byte writes carry half the payload of the 16-bit commands.
   function automatic int unsigned tx_payload_len(
      input logic [TX_CMD_BITS-1:0] cmd,
      input int unsigned            payload_cycles
   );
      return (cmd == TX_HEADER_WRITE_8) ? (payload_cycles / 2) : payload_cycles;
   endfunction

endpackage

// File: rtl/tx_serializer.sv
// Frame sequencer: shifts the {start, cmd} header out MSB first, then counts
// payload cycles until the command's length is reached.
module tx_serializer
   import tx_arbiter_pkg::*;
#(
   parameter int  NSHIFT         = 2,
   parameter int  PAYLOAD_CYCLES = 8,
   localparam int CW             = $clog2(PAYLOAD_CYCLES) + 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [TX_CMD_BITS-1:0] cmd,
   output logic                   in_header,
   output logic                   in_payload,
   output logic                   done,
   output logic [CW-1:0]          counter,
   output logic [NSHIFT-1:0]      header_slice
);

   localparam int HEADER_CYCLES = (1 + TX_CMD_BITS + NSHIFT - 1) / NSHIFT;
   localparam int HW            = HEADER_CYCLES * NSHIFT;
   localparam int HCW           = (HEADER_CYCLES > 1) ? $clog2(HEADER_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HEADER  = 2'd1,
      PAYLOAD = 2'd2
   } state_t;

   state_t           state;
   logic [HW-1:0]    shift_reg;
   logic [HCW-1:0]   hdr_cnt;
   logic [CW-1:0]    last_idx;
   logic [HW-1:0]    header_word;
   logic [CW-1:0]    load_last;

   assign header_word = HW'({TX_START_BIT, cmd});
   assign load_last   = CW'(tx_payload_len(cmd, PAYLOAD_CYCLES) - 1);

   assign in_header    = (state == HEADER);
   assign in_payload   = (state == PAYLOAD);
   assign done         = in_payload && (counter == last_idx);
   assign header_slice = shift_reg[HW-1 -: NSHIFT];

   // A start in the done cycle reloads the header directly, so frames can
   // run back to back without passing through IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         shift_reg <= '0;
         hdr_cnt   <= '0;
         counter   <= '0;
         last_idx  <= '0;
      end else begin
         case (state)
            IDLE: begin
               counter <= '0;
               if (start) begin
                  state     <= HEADER;
                  shift_reg <= header_word;
                  hdr_cnt   <= '0;
                  last_idx  <= load_last;
               end
            end
            HEADER: begin
               shift_reg <= shift_reg << NSHIFT;
               counter   <= '0;
               if (hdr_cnt == HCW'(HEADER_CYCLES - 1)) begin
                  state   <= PAYLOAD;
                  hdr_cnt <= '0;
               end else begin
                  hdr_cnt <= hdr_cnt + HCW'(1);
               end
            end
            PAYLOAD: begin
               if (done) begin
                  counter <= '0;
                  if (start) begin
                     state     <= HEADER;
                     shift_reg <= header_word;
                     hdr_cnt   <= '0;
                     last_idx  <= load_last;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  counter <= counter + CW'(1);
               end
            end
            default: begin
               state   <= IDLE;
               counter <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/tx_arbiter.sv
// Two-requester transmit arbiter: scheduler has priority and may reserve the
// channel against the prefetcher; the winner's frame goes out via tx_serializer.
module tx_arbiter
   import tx_arbiter_pkg::*;
#(
   parameter int  NSHIFT         = 2,
   parameter int  PAYLOAD_CYCLES = 8,
   localparam int CW             = $clog2(PAYLOAD_CYCLES) + 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   sched_cmd_valid,
   input  logic [TX_CMD_BITS-1:0] sched_cmd,
   input  logic                   sched_reserve,
   input  logic [NSHIFT-1:0]      sched_data,
   output logic                   sched_cmd_started,
   input  logic                   pf_cmd_valid,
   input  logic [TX_CMD_BITS-1:0] pf_cmd,
   input  logic [NSHIFT-1:0]      pf_data,
   output logic                   pf_cmd_started,
   output logic                   tx_active,
   output logic                   tx_owner,
   output logic                   tx_data_next,
   output logic [CW-1:0]          tx_counter,
   output logic                   tx_done,
   output logic [NSHIFT-1:0]      tx_pins
);

   logic                   in_header;
   logic                   in_payload;
   logic                   done;
   logic [NSHIFT-1:0]      header_slice;
   logic                   can_grant;
   logic                   grant_sched;
   logic                   grant_pf;
   logic                   start;
   logic [TX_CMD_BITS-1:0] grant_cmd;
   logic                   owner;

   // Gating with rst_n keeps the grant pulses quiet while reset is held.
   assign can_grant   = rst_n && (!(in_header || in_payload) || done);
   assign grant_sched = can_grant && sched_cmd_valid;
   assign grant_pf    = can_grant && pf_cmd_valid && !sched_cmd_valid && !sched_reserve;
   assign start       = grant_sched || grant_pf;
   assign grant_cmd   = grant_sched ? sched_cmd : pf_cmd;

   assign sched_cmd_started = grant_sched;
   assign pf_cmd_started    = grant_pf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner <= 1'b0;
      end else if (start) begin
         owner <= grant_sched;
      end
   end

   tx_serializer #(
      .NSHIFT         (NSHIFT),
      .PAYLOAD_CYCLES (PAYLOAD_CYCLES)
   ) u_serializer (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .cmd          (grant_cmd),
      .in_header    (in_header),
      .in_payload   (in_payload),
      .done         (done),
      .counter      (tx_counter),
      .header_slice (header_slice)
   );

   assign tx_active    = in_header || in_payload;
   assign tx_owner     = owner;
   assign tx_data_next = in_payload;
   assign tx_done      = done;

   // Payload bits pass straight through from the owner's lane.
   always_comb begin
      tx_pins = '0;
      if (in_payload) begin
         tx_pins = owner ? sched_data : pf_data;
      end else if (in_header) begin
         tx_pins = header_slice;
      end
   end

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter with NSHIFT=2, PAYLOAD_CYCLES=8; expected
// values are hand-derived per cycle.
module tb_tx_arbiter;

   logic       clk;
   logic       rst_n;
   logic       sched_cmd_valid;
   logic [1:0] sched_cmd;
   logic       sched_reserve;
   logic [1:0] sched_data;
   logic       sched_cmd_started;
   logic       pf_cmd_valid;
   logic [1:0] pf_cmd;
   logic [1:0] pf_data;
   logic       pf_cmd_started;
   logic       tx_active;
   logic       tx_owner;
   logic       tx_data_next;
   logic [3:0] tx_counter;
   logic       tx_done;
   logic [1:0] tx_pins;

   int checks   = 0;
   int failures = 0;

   tx_arbiter #(
      .NSHIFT         (2),
      .PAYLOAD_CYCLES (8)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .sched_cmd_valid   (sched_cmd_valid),
      .sched_cmd         (sched_cmd),
      .sched_reserve     (sched_reserve),
      .sched_data        (sched_data),
      .sched_cmd_started (sched_cmd_started),
      .pf_cmd_valid      (pf_cmd_valid),
      .pf_cmd            (pf_cmd),
      .pf_data           (pf_data),
      .pf_cmd_started    (pf_cmd_started),
      .tx_active         (tx_active),
      .tx_owner          (tx_owner),
      .tx_data_next      (tx_data_next),
      .tx_counter        (tx_counter),
      .tx_done           (tx_done),
      .tx_pins           (tx_pins)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Checks every cycle of a frame after its grant cycle: two header slices
   // (01 then cmd) followed by len payload cycles. New valid/cmd values are
   // applied in the first header cycle to show they do not disturb the frame.
   task automatic checkFrame(input string tag, input logic owner, input logic [1:0] hdr_cmd,
                             input logic [1:0] data, input int len,
                             input logic exp_pf_at_done, input logic exp_sched_at_done,
                             input logic new_sv, input logic new_pv, input logic [1:0] new_scmd);
      logic [1:0] slice;
      for (int h = 0; h < 2; h++) begin
         @(negedge clk);
         if (h == 0) begin
            sched_cmd_valid = new_sv;
            pf_cmd_valid    = new_pv;
            sched_cmd       = new_scmd;
         end
         #1;
         slice = (h == 0) ? 2'b01 : hdr_cmd;
         checkOutput({tag, ".hdr_active"}, 8'(tx_active), 8'd1);
         checkOutput({tag, ".hdr_owner"}, 8'(tx_owner), 8'(owner));
         checkOutput({tag, ".hdr_pins"}, 8'(tx_pins), 8'(slice));
         checkOutput({tag, ".hdr_dnext"}, 8'(tx_data_next), 8'd0);
         checkOutput({tag, ".hdr_cnt"}, 8'(tx_counter), 8'd0);
         checkOutput({tag, ".hdr_grants"}, {6'd0, sched_cmd_started, pf_cmd_started}, 8'd0);
      end
      for (int k = 0; k < len; k++) begin
         @(negedge clk);
         #1;
         checkOutput({tag, ".pl_active"}, 8'(tx_active), 8'd1);
         checkOutput({tag, ".pl_pins"}, 8'(tx_pins), 8'(data));
         checkOutput({tag, ".pl_dnext"}, 8'(tx_data_next), 8'd1);
         checkOutput({tag, ".pl_cnt"}, 8'(tx_counter), 8'(k));
         checkOutput({tag, ".pl_done"}, 8'(tx_done), 8'(k == len - 1));
         checkOutput({tag, ".pl_pf_start"}, 8'(pf_cmd_started),
                     (k == len - 1) ? 8'(exp_pf_at_done) : 8'd0);
         checkOutput({tag, ".pl_sched_start"}, 8'(sched_cmd_started),
                     (k == len - 1) ? 8'(exp_sched_at_done) : 8'd0);
      end
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, ".active"}, 8'(tx_active), 8'd0);
      checkOutput({tag, ".pins"}, 8'(tx_pins), 8'd0);
      checkOutput({tag, ".cnt"}, 8'(tx_counter), 8'd0);
      checkOutput({tag, ".done"}, 8'(tx_done), 8'd0);
      checkOutput({tag, ".dnext"}, 8'(tx_data_next), 8'd0);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n           = 1'b0;
      sched_cmd_valid = 1'b1;
      sched_cmd       = 2'd1;
      sched_reserve   = 1'b0;
      sched_data      = 2'b01;
      pf_cmd_valid    = 1'b1;
      pf_cmd          = 2'd1;
      pf_data         = 2'b10;

      // Reset held with both requesters valid: nothing may start.
      @(negedge clk); #1;
      checkIdle("rst");
      checkOutput("rst.owner", 8'(tx_owner), 8'd0);
      checkOutput("rst.sched_start", 8'(sched_cmd_started), 8'd0);
      checkOutput("rst.pf_start", 8'(pf_cmd_started), 8'd0);
      @(negedge clk);
      sched_cmd_valid = 1'b0;
      pf_cmd_valid    = 1'b0;
      rst_n           = 1'b1;
      #1;
      checkIdle("post_rst");
      checkOutput("post_rst.grants", {6'd0, sched_cmd_started, pf_cmd_started}, 8'd0);

      // Scheduler READ_16 from IDLE; valid drops and cmd changes mid-frame.
      @(negedge clk);
      sched_cmd_valid = 1'b1;
      sched_cmd       = 2'd1;
      sched_data      = 2'b10;
      #1;
      checkOutput("read16.grant", 8'(sched_cmd_started), 8'd1);
      checkOutput("read16.grant_pf", 8'(pf_cmd_started), 8'd0);
      checkIdle("read16.c0");
      checkFrame("read16", 1'b1, 2'd1, 2'b10, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
      @(negedge clk); #1;
      checkIdle("read16.after");

      // Both valid: scheduler WRITE_16 wins, prefetcher WRITE_8 follows back to back.
      @(negedge clk);
      sched_cmd_valid = 1'b1;
      sched_cmd       = 2'd2;
      sched_data      = 2'b01;
      pf_cmd_valid    = 1'b1;
      pf_cmd          = 2'd3;
      pf_data         = 2'b10;
      #1;
      checkOutput("both.sched_grant", 8'(sched_cmd_started), 8'd1);
      checkOutput("both.pf_grant", 8'(pf_cmd_started), 8'd0);
      checkFrame("both.sched", 1'b1, 2'd2, 2'b01, 8, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2);
      checkFrame("b2b.pf_w8", 1'b0, 2'd3, 2'b10, 4, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
      @(negedge clk); #1;
      checkIdle("b2b.after");

      // Reserve blocks the prefetcher for 20 cycles, grant on release.
      @(negedge clk);
      sched_reserve = 1'b1;
      pf_cmd_valid  = 1'b1;
      pf_cmd        = 2'd1;
      #1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         checkOutput("reserve.pf_blocked", 8'(pf_cmd_started), 8'd0);
         checkOutput("reserve.inactive", 8'(tx_active), 8'd0);
      end
      @(negedge clk);
      sched_reserve = 1'b0;
      #1;
      checkOutput("reserve.release_grant", 8'(pf_cmd_started), 8'd1);
      checkFrame("reserve.pf", 1'b0, 2'd1, 2'b10, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);

      // Reserve never blocks the scheduler.
      @(negedge clk);
      sched_reserve   = 1'b1;
      sched_cmd_valid = 1'b1;
      sched_cmd       = 2'd3;
      #1;
      checkOutput("reserve.sched_grant", 8'(sched_cmd_started), 8'd1);
      checkFrame("reserve.sched_w8", 1'b1, 2'd3, 2'b01, 4, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
      sched_reserve = 1'b0;

      // Reset during payload cycle 3 aborts the frame at once.
      @(negedge clk);
      sched_cmd_valid = 1'b1;
      sched_cmd       = 2'd2;
      #1;
      checkOutput("abort.grant", 8'(sched_cmd_started), 8'd1);
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         if (i == 1) sched_cmd_valid = 1'b0;
         #1;
      end
      checkOutput("abort.cnt_before", 8'(tx_counter), 8'd3);
      checkOutput("abort.active_before", 8'(tx_active), 8'd1);
      rst_n           = 1'b0;
      sched_cmd_valid = 1'b1;
      #1;
      checkIdle("abort.in_reset");
      checkOutput("abort.sched_start", 8'(sched_cmd_started), 8'd0);
      @(negedge clk); #1;
      checkIdle("abort.held");
      @(negedge clk);
      sched_cmd_valid = 1'b0;
      rst_n           = 1'b1;
      #1;
      checkIdle("abort.release");
      @(negedge clk); #1;
      checkIdle("abort.idle");
      checkOutput("abort.owner", 8'(tx_owner), 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
